// File: rtl/decode_pkg.sv
// decode_pkg: shared instruction-type encodings and counter widths for operand_decode.
package decode_pkg;
  typedef enum logic [2:0] {
    INST_NOP = 3'd0,
    INST_BEQ = 3'd5
  } inst_e;
  localparam int STALL_W = 16;
  localparam int JOFF_W = 26;
endpackage

// File: rtl/operand_decode_if.sv
// operand_decode_if: instruction, writeback, EX-hazard and decoded-operand signals of operand_decode.
interface operand_decode_if #(
  parameter int DATA_W = 32,
  parameter int AW = 5,
  parameter int IMM_W = 16
);
  import decode_pkg::*;
  logic in_valid_x70;
  logic in_ready_x70;
  logic [2:0] inst_type_x70;
  logic [AW-1:0] rs1_x70;
  logic [AW-1:0] rs2_x70;
  logic [AW-1:0] rd_x70;
  logic has_imm_x70;
  logic [IMM_W-1:0] imm_x70;
  logic [JOFF_W-1:0] Joffset_x70;
  logic wb_en_x70;
  logic [AW-1:0] wb_dest_x70;
  logic [DATA_W-1:0] wb_data_x70;
  logic ex_load_x70;
  logic [AW-1:0] ex_dest_x70;
  logic out_valid_x70;
  logic out_ready_x70;
  logic signed [DATA_W-1:0] A_x70;
  logic signed [DATA_W-1:0] B_x70;
  logic [AW-1:0] sourceA_x70;
  logic [AW-1:0] sourceB_x70;
  logic [2:0] inst_type_fwd_x70;
  logic [JOFF_W-1:0] Joffset_fwd_x70;
  logic [AW-1:0] target_fwd_x70;
  logic [STALL_W-1:0] stall_cnt_x70;
  modport slave (
    input in_valid_x70, inst_type_x70, rs1_x70, rs2_x70, rd_x70, has_imm_x70, imm_x70,
          Joffset_x70, wb_en_x70, wb_dest_x70, wb_data_x70, ex_load_x70, ex_dest_x70,
          out_ready_x70,
    output in_ready_x70, out_valid_x70, A_x70, B_x70, sourceA_x70, sourceB_x70,
           inst_type_fwd_x70, Joffset_fwd_x70, target_fwd_x70, stall_cnt_x70
  );
  modport master (
    output in_valid_x70, inst_type_x70, rs1_x70, rs2_x70, rd_x70, has_imm_x70, imm_x70,
           Joffset_x70, wb_en_x70, wb_dest_x70, wb_data_x70, ex_load_x70, ex_dest_x70,
           out_ready_x70,
    input in_ready_x70, out_valid_x70, A_x70, B_x70, sourceA_x70, sourceB_x70,
          inst_type_fwd_x70, Joffset_fwd_x70, target_fwd_x70, stall_cnt_x70
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with hardwired R0 and same-cycle writeback bypass.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic w_wr;
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    else if (w_wr) r_mem[i_wa] <= i_wd;
  end
  always_comb begin
    w_wr = i_we && i_wa != '0;
    o_rd1 = i_ra1 == '0 ? '0 : (w_wr && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    o_rd2 = i_ra2 == '0 ? '0 : (w_wr && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
  end
endmodule

// File: rtl/operand_decode.sv
// operand_decode: fetches operands for a decoded instruction, extends immediates,
// stalls on load-use hazards and presents results through a one-entry valid/ready register.
module operand_decode #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int IMM_W = 16,
  parameter int SIGN_EXT = 1
) (
  input logic clk_x70,
  input logic rst_x70,
  operand_decode_if.slave bus
);
  import decode_pkg::*;
  localparam int AW = $clog2(NUM_REGS);
  logic w_nop, w_use_b, w_hazard, w_ready, w_accept;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_imm;
  logic r_valid;
  logic [DATA_W-1:0] r_a, r_b;
  logic [AW-1:0] r_sa, r_sb, r_tgt;
  logic [2:0] r_type;
  logic [JOFF_W-1:0] r_joff;
  logic [STALL_W-1:0] r_stall;
  reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk_x70),
    .rst(rst_x70),
    .i_we(bus.wb_en_x70),
    .i_wa(bus.wb_dest_x70),
    .i_wd(bus.wb_data_x70),
    .i_ra1(bus.rs1_x70),
    .i_ra2(bus.rs2_x70),
    .o_rd1(w_rd1),
    .o_rd2(w_rd2)
  );
  always_comb begin
    w_nop = bus.inst_type_x70 == INST_NOP;
    w_use_b = bus.inst_type_x70 == INST_BEQ || !bus.has_imm_x70;
    w_hazard = bus.in_valid_x70 && bus.ex_load_x70 && bus.ex_dest_x70 != '0 && !w_nop &&
               (bus.ex_dest_x70 == bus.rs1_x70 || (w_use_b && bus.ex_dest_x70 == bus.rs2_x70));
    w_ready = (!r_valid || bus.out_ready_x70) && !w_hazard;
    w_accept = bus.in_valid_x70 && w_ready;
    w_imm = {{(DATA_W-IMM_W){SIGN_EXT != 0 && bus.imm_x70[IMM_W-1]}}, bus.imm_x70};
  end
  always_ff @(posedge clk_x70) begin
    if (rst_x70) begin
      r_valid <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_sa <= '0;
      r_sb <= '0;
      r_tgt <= '0;
      r_type <= '0;
      r_joff <= '0;
      r_stall <= '0;
    end else begin
      r_valid <= w_accept || (r_valid && !bus.out_ready_x70);
      if (w_accept) begin
        r_a <= w_nop ? '0 : w_rd1;
        r_b <= w_nop ? '0 : w_use_b ? w_rd2 : w_imm;
        r_sa <= w_nop ? '0 : bus.rs1_x70;
        r_sb <= (w_nop || !w_use_b) ? '0 : bus.rs2_x70;
        r_tgt <= bus.rd_x70;
        r_type <= bus.inst_type_x70;
        r_joff <= bus.Joffset_x70;
      end
      if (w_hazard && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
  end
  assign bus.in_ready_x70 = w_ready;
  assign bus.out_valid_x70 = r_valid;
  assign bus.A_x70 = r_a;
  assign bus.B_x70 = r_b;
  assign bus.sourceA_x70 = r_sa;
  assign bus.sourceB_x70 = r_sb;
  assign bus.target_fwd_x70 = r_tgt;
  assign bus.inst_type_fwd_x70 = r_type;
  assign bus.Joffset_fwd_x70 = r_joff;
  assign bus.stall_cnt_x70 = r_stall;
endmodule

// File: tb/tb_operand_decode.sv
// tb_operand_decode: directed and random stimulus on sign- and zero-extending instances,
// checked every cycle against a behavioural model.
module tb_operand_decode;
  localparam int DW = 32, NR = 32, AW = 5, IW = 16;
  logic clk_x70 = 1'b0;
  logic rst_x70 = 1'b1;
  always #5 clk_x70 = ~clk_x70;
  operand_decode_if #(.DATA_W(DW), .AW(AW), .IMM_W(IW)) bus1();
  operand_decode_if #(.DATA_W(DW), .AW(AW), .IMM_W(IW)) bus0();
  operand_decode #(.DATA_W(DW), .NUM_REGS(NR), .IMM_W(IW), .SIGN_EXT(1)) dut1 (
    .clk_x70(clk_x70), .rst_x70(rst_x70), .bus(bus1.slave));
  operand_decode #(.DATA_W(DW), .NUM_REGS(NR), .IMM_W(IW), .SIGN_EXT(0)) dut0 (
    .clk_x70(clk_x70), .rst_x70(rst_x70), .bus(bus0.slave));
  assign bus0.in_valid_x70 = bus1.in_valid_x70;
  assign bus0.inst_type_x70 = bus1.inst_type_x70;
  assign bus0.rs1_x70 = bus1.rs1_x70;
  assign bus0.rs2_x70 = bus1.rs2_x70;
  assign bus0.rd_x70 = bus1.rd_x70;
  assign bus0.has_imm_x70 = bus1.has_imm_x70;
  assign bus0.imm_x70 = bus1.imm_x70;
  assign bus0.Joffset_x70 = bus1.Joffset_x70;
  assign bus0.wb_en_x70 = bus1.wb_en_x70;
  assign bus0.wb_dest_x70 = bus1.wb_dest_x70;
  assign bus0.wb_data_x70 = bus1.wb_data_x70;
  assign bus0.ex_load_x70 = bus1.ex_load_x70;
  assign bus0.ex_dest_x70 = bus1.ex_dest_x70;
  assign bus0.out_ready_x70 = bus1.out_ready_x70;

  int n_pass = 0, n_chk = 0;
  logic [DW-1:0] m_rf [NR];
  logic m_valid;
  logic [DW-1:0] m_a, m_b1, m_b0;
  logic [AW-1:0] m_sa, m_sb, m_tgt;
  logic [2:0] m_type;
  logic [25:0] m_joff;
  int m_stall;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_valid = 0; m_a = 0; m_b1 = 0; m_b0 = 0; m_sa = 0; m_sb = 0;
    m_tgt = 0; m_type = 0; m_joff = 0; m_stall = 0;
  endtask

  function automatic logic [DW-1:0] src(logic [AW-1:0] r);
    if (r == 0) return '0;
    if (bus1.wb_en_x70 && bus1.wb_dest_x70 == r) return bus1.wb_data_x70;
    return m_rf[r];
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(bus1.out_valid_x70), 32'(m_valid));
    check("A", bus1.A_x70, m_a);
    check("B", bus1.B_x70, m_b1);
    check("sourceA", 32'(bus1.sourceA_x70), 32'(m_sa));
    check("sourceB", 32'(bus1.sourceB_x70), 32'(m_sb));
    check("type_fwd", 32'(bus1.inst_type_fwd_x70), 32'(m_type));
    check("joff_fwd", 32'(bus1.Joffset_fwd_x70), 32'(m_joff));
    check("target_fwd", 32'(bus1.target_fwd_x70), 32'(m_tgt));
    check("stall_cnt", 32'(bus1.stall_cnt_x70), 32'(m_stall));
    check("zx_out_valid", 32'(bus0.out_valid_x70), 32'(m_valid));
    check("zx_A", bus0.A_x70, m_a);
    check("zx_B", bus0.B_x70, m_b0);
    check("zx_sourceB", 32'(bus0.sourceB_x70), 32'(m_sb));
  endtask

  task automatic tick();
    logic [2:0] t;
    logic [DW-1:0] imm_s, imm_z;
    bit use_b, nop, hz, rdy, acc;
    @(negedge clk_x70);
    t = bus1.inst_type_x70;
    nop = t == 3'd0;
    use_b = t == 3'd5 || !bus1.has_imm_x70;
    hz = bus1.in_valid_x70 && bus1.ex_load_x70 && bus1.ex_dest_x70 != 0 && !nop &&
         (bus1.ex_dest_x70 == bus1.rs1_x70 || (use_b && bus1.ex_dest_x70 == bus1.rs2_x70));
    rdy = (!m_valid || bus1.out_ready_x70) && !hz;
    acc = bus1.in_valid_x70 && rdy;
    check("in_ready", 32'(bus1.in_ready_x70), 32'(rdy));
    check("zx_in_ready", 32'(bus0.in_ready_x70), 32'(rdy));
    check_outputs();
    if (rst_x70) model_reset();
    else begin
      if (acc) begin
        imm_s = $signed(bus1.imm_x70);
        imm_z = bus1.imm_x70;
        m_a = nop ? '0 : src(bus1.rs1_x70);
        m_b1 = nop ? '0 : use_b ? src(bus1.rs2_x70) : imm_s;
        m_b0 = nop ? '0 : use_b ? src(bus1.rs2_x70) : imm_z;
        m_sa = nop ? '0 : bus1.rs1_x70;
        m_sb = (nop || !use_b) ? '0 : bus1.rs2_x70;
        m_type = t;
        m_joff = bus1.Joffset_x70;
        m_tgt = bus1.rd_x70;
      end
      m_valid = acc || (m_valid && !bus1.out_ready_x70);
      if (hz && m_stall < 65535) m_stall++;
      if (bus1.wb_en_x70 && bus1.wb_dest_x70 != 0) m_rf[bus1.wb_dest_x70] = bus1.wb_data_x70;
    end
    @(posedge clk_x70);
    #1;
  endtask

  task automatic idle();
    bus1.in_valid_x70 = 0; bus1.inst_type_x70 = 3'd1; bus1.rs1_x70 = 0; bus1.rs2_x70 = 0;
    bus1.rd_x70 = 0; bus1.has_imm_x70 = 0; bus1.imm_x70 = 0; bus1.Joffset_x70 = 0;
    bus1.wb_en_x70 = 0; bus1.wb_dest_x70 = 0; bus1.wb_data_x70 = 0;
    bus1.ex_load_x70 = 0; bus1.ex_dest_x70 = 0; bus1.out_ready_x70 = 1;
  endtask

  task automatic rand_inputs();
    bus1.in_valid_x70 = $urandom_range(0, 3) != 0;
    bus1.inst_type_x70 = 3'($urandom_range(0, 7));
    bus1.rs1_x70 = AW'($urandom_range(0, 7));
    bus1.rs2_x70 = AW'($urandom_range(0, 7));
    bus1.rd_x70 = AW'($urandom());
    bus1.has_imm_x70 = 1'($urandom());
    bus1.imm_x70 = IW'($urandom());
    bus1.Joffset_x70 = 26'($urandom());
    bus1.wb_en_x70 = 1'($urandom());
    bus1.wb_dest_x70 = AW'($urandom_range(0, 7));
    bus1.wb_data_x70 = $urandom();
    bus1.ex_load_x70 = $urandom_range(0, 2) == 0;
    bus1.ex_dest_x70 = AW'($urandom_range(0, 7));
    bus1.out_ready_x70 = $urandom_range(0, 3) != 0;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk_x70);
    #1;
    tick();
    rst_x70 = 0;
    // writeback R3=42 bypassed into a same-cycle read
    bus1.in_valid_x70 = 1; bus1.rs1_x70 = 3;
    bus1.wb_en_x70 = 1; bus1.wb_dest_x70 = 3; bus1.wb_data_x70 = 42;
    tick();
    check("byp_A", bus1.A_x70, 32'd42);
    check("byp_sourceA", 32'(bus1.sourceA_x70), 32'd3);
    idle();
    // immediate extension in both instances
    bus1.in_valid_x70 = 1; bus1.inst_type_x70 = 3'd2; bus1.has_imm_x70 = 1; bus1.imm_x70 = 16'hFFFF;
    tick();
    check("imm_sext_B", bus1.B_x70, 32'hFFFF_FFFF);
    check("imm_zext_B", bus0.B_x70, 32'h0000_FFFF);
    check("imm_sext_srcB", 32'(bus1.sourceB_x70), 32'd0);
    check("imm_zext_srcB", 32'(bus0.sourceB_x70), 32'd0);
    idle();
    // load-use stall for two cycles
    bus1.in_valid_x70 = 1; bus1.rs1_x70 = 1; bus1.rs2_x70 = 4;
    bus1.ex_load_x70 = 1; bus1.ex_dest_x70 = 4;
    #1 check("lu_ready0", 32'(bus1.in_ready_x70), 32'd0);
    tick();
    check("lu_bubble", 32'(bus1.out_valid_x70), 32'd0);
    check("lu_ready1", 32'(bus1.in_ready_x70), 32'd0);
    tick();
    bus1.ex_load_x70 = 0;
    #1 check("lu_ready2", 32'(bus1.in_ready_x70), 32'd1);
    check("lu_stall", 32'(bus1.stall_cnt_x70), 32'd2);
    tick();
    check("lu_pass_valid", 32'(bus1.out_valid_x70), 32'd1);
    check("lu_pass_srcB", 32'(bus1.sourceB_x70), 32'd4);
    idle();
    // backpressure holds A=42, B=5
    bus1.in_valid_x70 = 1; bus1.rs1_x70 = 3; bus1.has_imm_x70 = 1; bus1.imm_x70 = 5;
    tick();
    bus1.out_ready_x70 = 0; bus1.rs1_x70 = 1; bus1.imm_x70 = 9;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", 32'(bus1.in_ready_x70), 32'd0);
      tick();
      check("bp_A", bus1.A_x70, 32'd42);
      check("bp_B", bus1.B_x70, 32'd5);
      check("bp_valid", 32'(bus1.out_valid_x70), 32'd1);
    end
    idle();
    tick();
    // R0 write dropped, then reset during a hold overrides a writeback
    bus1.in_valid_x70 = 1; bus1.wb_en_x70 = 1; bus1.wb_dest_x70 = 0; bus1.wb_data_x70 = 7;
    tick();
    bus1.wb_en_x70 = 0;
    tick();
    check("r0_A", bus1.A_x70, 32'd0);
    bus1.in_valid_x70 = 0; bus1.out_ready_x70 = 0;
    tick();
    rst_x70 = 1; bus1.wb_en_x70 = 1; bus1.wb_dest_x70 = 3; bus1.wb_data_x70 = 99;
    tick();
    rst_x70 = 0;
    idle();
    check("rst_valid", 32'(bus1.out_valid_x70), 32'd0);
    bus1.in_valid_x70 = 1; bus1.rs1_x70 = 3; bus1.rs2_x70 = 4;
    tick();
    check("rst_rf_A", bus1.A_x70, 32'd0);
    check("rst_rf_B", bus1.B_x70, 32'd0);
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      rst_x70 = $urandom_range(0, 99) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
